// File: rtl/rr_grant_arbiter_4.sv
// rr_grant_arbiter_4
//   Four-requester round-robin arbiter with a registered one-hot grant.
//   A requester keeps ownership for as long as it holds its request line,
//   but only for MAX_HOLD consecutive cycles while someone else is waiting.
//   After that it is preempted and the grant moves on in round-robin order.
//   The grant is always one-hot or all-zero, so a downstream one-hot
//   encoder never sees an illegal code.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req[3:0]     request lines, held high while the requester wants ownership
//   grant[3:0]   registered one-hot grant, 4'b0000 when idle
//   grant_valid  registered, always equal to |grant
//   preempt      registered one-cycle pulse on the first cycle of a grant
//                taken from an owner that was still requesting
//
// state | meaning
// IDLE  | no owner, grant is zero, waiting for any request
// GRANT | owner own_q holds the grant, hold_q counts its consecutive cycles

module rr_grant_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic       preempt
);

  // Hold limit compared as an unsigned 4-bit value; legal range 1..15.
  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] own_q, own_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] grant_q, grant_d;
  logic       valid_q;
  logic       preempt_q, preempt_d;

  logic [3:0] own_oh;
  logic [3:0] others;
  logic [1:0] own_nxt;

  // First index with mask set, scanning start, start+1, ... modulo 4.
  // Callers only use the result when mask is non-zero.
  function automatic logic [1:0] sel(input logic [1:0] start,
                                     input logic [3:0] mask);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    own_oh    = 4'b0001 << own_q;
    others    = req & ~own_oh;
    own_nxt   = own_q + 2'd1;

    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          own_d   = sel(ptr_q, req);
          hold_d  = 4'd1;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (!req[own_q]) begin
          // Release always advances the pointer past the old owner.
          ptr_d = own_nxt;
          if (|others) begin
            // Direct handoff, no idle bubble.
            own_d  = sel(own_nxt, others);
            hold_d = 4'd1;
          end else begin
            state_d = IDLE;
            hold_d  = 4'd0;
          end
        end else if (hold_q == MaxHold) begin
          if (|others) begin
            own_d     = sel(own_nxt, others);
            hold_d    = 4'd1;
            preempt_d = 1'b1;
            ptr_d     = own_nxt;
          end
          // No competitor: keep the grant, counter stays saturated so a
          // later competitor preempts on the very next edge.
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    grant_d = (state_d == GRANT) ? (4'b0001 << own_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      own_q     <= 2'd0;
      hold_q    <= 4'd0;
      grant_q   <= 4'b0000;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      valid_q   <= |grant_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter_4.sv
// Testbench for rr_grant_arbiter_4.
// A reference model predicts {grant, grant_valid, preempt} at every rising
// edge and pushes it to a scoreboard queue; the falling-edge monitor pops and
// compares, and also checks the output invariants and the wait bound.
// Directed scenario tasks add their own constant expectations.

module tb_rr_grant_arbiter_4;

  localparam int MAX_HOLD   = 8;
  localparam int FAIR_BOUND = 3 * MAX_HOLD + 1;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] grant;
  logic       grant_valid;
  logic       preempt;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] sb_q[$];

  rr_grant_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_owner = 0;
  int         m_ptr   = 0;
  int         m_hold  = 0;
  bit         m_busy  = 1'b0;
  bit         m_pre   = 1'b0;
  logic [3:0] m_grant = 4'b0000;
  logic [3:0] m_others;

  function automatic int pick(input int start, input logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      if (mask[(start + k) % 4]) return (start + k) % 4;
    end
    return 0;
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] w);
    case (w)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0; m_pre = 1'b0; m_ptr = 0; m_hold = 0; m_owner = 0;
    end else begin
      m_pre = 1'b0;
      if (!m_busy) begin
        if (req != 4'b0000) begin
          m_owner = pick(m_ptr, req);
          m_busy  = 1'b1;
          m_hold  = 1;
        end
      end else begin
        m_others = req;
        m_others[m_owner] = 1'b0;
        if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % 4;
          if (m_others != 4'b0000) begin
            m_owner = pick(m_ptr, m_others);
            m_hold  = 1;
          end else begin
            m_busy = 1'b0;
          end
        end else if (m_hold >= MAX_HOLD) begin
          if (m_others != 4'b0000) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = pick(m_ptr, m_others);
            m_hold  = 1;
            m_pre   = 1'b1;
          end
        end else begin
          m_hold = m_hold + 1;
        end
      end
    end
    m_grant = m_busy ? 4'(1 << m_owner) : 4'b0000;
    sb_q.push_back({m_grant, |m_grant, m_pre});
  end

  // ---------------- monitor ----------------
  logic [5:0] sb_exp;
  int         wait_cnt[4];
  int         grants_seen = 0;

  initial forever begin
    @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got no prediction, required one per edge");
    end else begin
      sb_exp = sb_q.pop_front();
      if ({grant, grant_valid, preempt} !== sb_exp) begin
        n_errors++;
        $display("FAIL scoreboard t=%0t: got grant=%b gv=%b pre=%b, required grant=%b gv=%b pre=%b",
                 $time, grant, grant_valid, preempt, sb_exp[5:2], sb_exp[1], sb_exp[0]);
      end
    end

    n_checks++;
    if (!$onehot0(grant) || (grant_valid !== (|grant)) || (preempt && !grant_valid)) begin
      n_errors++;
      $display("FAIL invariant t=%0t: got grant=%b gv=%b pre=%b, required onehot0, gv==|grant, pre->gv",
               $time, grant, grant_valid, preempt);
    end

    if (grant_valid === 1'b1) grants_seen++;

    n_checks++;
    for (int i = 0; i < 4; i++) begin
      if (reset || !req[i] || grant[i]) wait_cnt[i] = 0;
      else wait_cnt[i] = wait_cnt[i] + 1;
      if (wait_cnt[i] > FAIR_BOUND) begin
        n_errors++;
        $display("FAIL fairness t=%0t: requester %0d waited %0d cycles, required <= %0d",
                 $time, i, wait_cnt[i], FAIR_BOUND);
        wait_cnt[i] = 0;
      end
    end
  end

  // Called at a falling edge: change inputs shortly after it, then return at
  // the next falling edge so the rising edge in between has sampled them.
  task automatic step(input logic [3:0] r, input logic rst);
    #1;
    req   = r;
    reset = rst;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(4'b1111, 1'b1);
      n_checks++;
      if ({grant, grant_valid, preempt} !== 6'b0) begin
        n_errors++;
        $display("FAIL reset_outputs: got grant=%b gv=%b pre=%b, required all zero",
                 grant, grant_valid, preempt);
      end
    end
    step(4'b1111, 1'b0);
    n_checks++;
    if (grant !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_first_grant: got %b, required 0001", grant);
    end
    step(4'b1111, 1'b0);
    n_checks++;
    if (enc(grant) !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_encoder_y: got %b, required 00", enc(grant));
    end
    step(4'b0000, 1'b0);
  endtask

  task automatic test_idle_grant();
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    n_checks++;
    if (grant_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_quiet: got gv=%b, required 0", grant_valid);
    end
    step(4'b0100, 1'b0);
    n_checks++;
    if (grant !== 4'b0100 || grant_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_grant: got grant=%b gv=%b, required 0100 1", grant, grant_valid);
    end
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_release: got grant=%b gv=%b, required 0000 0", grant, grant_valid);
    end
    step(4'b1001, 1'b0);
    n_checks++;
    if (grant !== 4'b1000) begin
      n_errors++;
      $display("FAIL idle_ptr_after_release: got %b, required 1000", grant);
    end
    step(4'b0000, 1'b0);
  endtask

  task automatic test_handoff();
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    n_checks++;
    if (grant !== 4'b0010) begin
      n_errors++;
      $display("FAIL handoff_owner_kept: got %b, required 0010", grant);
    end
    step(4'b1000, 1'b0);
    n_checks++;
    if (grant !== 4'b1000 || grant_valid !== 1'b1 || preempt !== 1'b0) begin
      n_errors++;
      $display("FAIL handoff_direct: got grant=%b gv=%b pre=%b, required 1000 1 0",
               grant, grant_valid, preempt);
    end
    step(4'b0000, 1'b0);
  endtask

  task automatic test_preempt_alternate();
    logic [3:0] exp_g;
    logic       exp_p;
    step(4'b0000, 1'b1);
    for (int c = 0; c < 40; c++) begin
      step(4'b0011, 1'b0);
      exp_g = (((c / MAX_HOLD) % 2) == 0) ? 4'b0001 : 4'b0010;
      exp_p = (c > 0) && ((c % MAX_HOLD) == 0);
      n_checks++;
      if (grant !== exp_g || preempt !== exp_p) begin
        n_errors++;
        $display("FAIL preempt_alternate cycle %0d: got grant=%b pre=%b, required %b %b",
                 c, grant, preempt, exp_g, exp_p);
      end
    end
  endtask

  task automatic test_saturate();
    step(4'b0000, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step(4'b1000, 1'b0);
      n_checks++;
      if (grant !== 4'b1000 || preempt !== 1'b0) begin
        n_errors++;
        $display("FAIL saturate_hold cycle %0d: got grant=%b pre=%b, required 1000 0",
                 c, grant, preempt);
      end
    end
    step(4'b1001, 1'b0);
    n_checks++;
    if (grant !== 4'b0001 || preempt !== 1'b1) begin
      n_errors++;
      $display("FAIL saturate_preempt: got grant=%b pre=%b, required 0001 1", grant, preempt);
    end
    step(4'b1001, 1'b0);
    n_checks++;
    if (preempt !== 1'b0) begin
      n_errors++;
      $display("FAIL saturate_pulse_width: got pre=%b, required 0", preempt);
    end
  endtask

  task automatic test_reset_mid();
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1100, 1'b1);
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_drop: got grant=%b gv=%b, required 0000 0", grant, grant_valid);
    end
    step(4'b1100, 1'b0);
    n_checks++;
    if (grant !== 4'b0100) begin
      n_errors++;
      $display("FAIL reset_mid_ptr: got %b, required 0100", grant);
    end
  endtask

  task automatic test_soak();
    logic [3:0] r;
    int         seen_before;
    r = 4'b0000;
    step(4'b0000, 1'b1);
    seen_before = grants_seen;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      end
      step(r, 1'b0);
    end
    n_checks++;
    if (grants_seen == seen_before) begin
      n_errors++;
      $display("FAIL soak_activity: got %0d grant cycles, required more than 0",
               grants_seen - seen_before);
    end
    step(4'b0000, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_grant();
    test_handoff();
    test_preempt_alternate();
    test_saturate();
    test_reset_mid();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
